// File: rtl/dec38_pkg.sv
// Shared types and helpers for the sequenced 3-to-8 one-hot decoder.
package dec38_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_e;

    function automatic logic [ONEHOT_W-1:0] onehot3(input logic [CODE_W-1:0] code);
        onehot3 = ONEHOT_W'(1) << code;
    endfunction

endpackage

// File: rtl/dec38_fifo.sv
// Synchronous code FIFO; pointers carry one extra wrap bit to tell full from empty.
module dec38_fifo
    import dec38_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [CODE_W-1:0] din,
    output logic [CODE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign dout  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; contents are only observed through dout when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/dec38_seq.sv
// Sequenced 3-to-8 one-hot decoder: FIFO-buffered codes shown for DWELL cycles plus GAP blanks.
// Optional sticky overflow flag output ovf_err when DEC38_OVF_ERR_EN is defined.
module dec38_seq #(
    parameter int DWELL = 4,
    parameter int GAP   = 1,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    output logic [7:0] y,
    output logic       y_valid,
    output logic       busy
`ifdef DEC38_OVF_ERR_EN
    ,
    output logic       ovf_err
`endif
);

    import dec38_pkg::*;

    localparam int CNT_RANGE = (DWELL > GAP) ? ((DWELL > 2) ? DWELL : 2)
                                             : ((GAP > 2) ? GAP : 2);
    localparam int CNT_W = $clog2(CNT_RANGE);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ONEHOT_W-1:0] y_q, y_d;
    logic                y_valid_q, y_valid_d;
    logic                push, pop, full, empty;
    logic [CODE_W-1:0]   fifo_dout;

    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign busy     = (state_q != IDLE) || !empty;
    assign y        = y_q;
    assign y_valid  = y_valid_q;

    dec38_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_code),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    // A pop always loads the new pattern and restarts the dwell count in the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                y_d = '0;
                if (en && !empty) begin
                    pop     = 1'b1;
                    y_d     = onehot3(fifo_dout);
                    cnt_d   = DWELL_LOAD;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (!en) begin
                    y_d     = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (GAP > 0) begin
                    y_d     = '0;
                    cnt_d   = GAP_LOAD;
                    state_d = dec38_pkg::GAP;
                end else if (!empty) begin
                    pop   = 1'b1;
                    y_d   = onehot3(fifo_dout);
                    cnt_d = DWELL_LOAD;
                end else begin
                    y_d     = '0;
                    state_d = IDLE;
                end
            end
            dec38_pkg::GAP: begin
                y_d = '0;
                if (!en) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!empty) begin
                    // Chaining the next pop here keeps the blank between patterns at exactly GAP cycles.
                    pop     = 1'b1;
                    y_d     = onehot3(fifo_dout);
                    cnt_d   = DWELL_LOAD;
                    state_d = SHOW;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                y_d     = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        y_valid_d = (y_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

`ifdef DEC38_OVF_ERR_EN
    logic ovf_err_q, ovf_err_d;

    assign ovf_err = ovf_err_q;

    always_comb begin
        ovf_err_d = ovf_err_q || (in_valid && !in_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_err_q <= 1'b0;
        else     ovf_err_q <= ovf_err_d;
    end
`endif

endmodule
